// File: rtl/fifo_wptr_full.sv
// Write-clock-domain controller of an async FIFO: binary/Gray write pointer,
// read-pointer synchroniser, and full / almost-full / level / overflow flags.
module fifo_wptr_full #(
  parameter int ADDRSIZE    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 12
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr_gray,
  input  logic                wovf_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic                wclken,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  localparam logic [ADDRSIZE:0] AF_LVL = (ADDRSIZE+1)'(AF_THRESH);

  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [ADDRSIZE:0] bin2gray(input logic [ADDRSIZE:0] b);
    return (b >> 1) ^ b;
  endfunction

  logic [ADDRSIZE:0] sync_r [SYNC_STAGES];
  logic [ADDRSIZE:0] wbin_r;
  logic [ADDRSIZE:0] rq_s;
  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] wbinnext_s;
  logic [ADDRSIZE:0] wgraynext_s;
  logic [ADDRSIZE:0] diff_s;
  logic [ADDRSIZE:0] full_cmp_s;
  logic              accept_s;

  assign rq_s        = sync_r[SYNC_STAGES-1];
  assign rbin_s      = gray2bin(rq_s);
  assign accept_s    = winc & ~wfull;
  assign wbinnext_s  = wbin_r + {{ADDRSIZE{1'b0}}, accept_s};
  assign wgraynext_s = bin2gray(wbinnext_s);
  assign diff_s      = wbinnext_s - rbin_s;
  // Full when the write pointer is exactly one lap (DEPTH) ahead of the synchronised read pointer.
  assign full_cmp_s  = {~rq_s[ADDRSIZE:ADDRSIZE-1], rq_s[ADDRSIZE-2:0]};

  assign waddr  = wbin_r[ADDRSIZE-1:0];
  assign wclken = accept_s;

  // Read-pointer synchroniser chain into the write clock domain.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= '0;
      end
    end else begin
      sync_r[0] <= rptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // Write pointers, status flags and the sticky overflow error.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_r       <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      woverflow    <= 1'b0;
    end else begin
      wbin_r       <= wbinnext_s;
      wptr         <= wgraynext_s;
      wfull        <= (wgraynext_s == full_cmp_s);
      walmost_full <= (diff_s >= AF_LVL);
      wlevel       <= diff_s;
      // A new overflow takes priority over a same-cycle clear.
      if (winc && wfull) begin
        woverflow <= 1'b1;
      end else if (wovf_clr) begin
        woverflow <= 1'b0;
      end else begin
        woverflow <= woverflow;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full: vector table, integer reference model
// feeding a scoreboard queue, wrap sequence and an asynchronous read-clock phase.
`timescale 1ns/100ps
module tb_fifo_wptr_full;

  logic       wclk = 1'b0;
  logic       rclk = 1'b0;
  logic       wrst_n;
  logic       winc;
  logic [4:0] rptr_gray;
  logic       wovf_clr;
  logic [3:0] waddr;
  logic       wclken;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       woverflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int lvl; int full; int af; int ovf; int addr; int ptr;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    bit winc; bit clr; int rd;
    int e_lvl; int e_full; int e_af; int e_ovf;
  } vec_t;
  vec_t vecs[28];

  // reference model state (absolute integer counts)
  int m_wcnt, m_rs0, m_rs1, m_full, m_ovf;

  int  rd_cnt_main = 0;
  int  rd_cnt_cdc  = 0;
  int  acc_cnt     = 0;
  bit  cdc_mode    = 1'b0;

  function automatic logic [4:0] gray5(input int v);
    logic [4:0] b;
    b = v[4:0];
    return b ^ (b >> 1);
  endfunction

  assign rptr_gray = cdc_mode ? gray5(rd_cnt_cdc) : gray5(rd_cnt_main);

  fifo_wptr_full #(.ADDRSIZE(4), .SYNC_STAGES(2), .AF_THRESH(12)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .rptr_gray(rptr_gray),
    .wovf_clr(wovf_clr), .waddr(waddr), .wclken(wclken), .wptr(wptr),
    .wfull(wfull), .walmost_full(walmost_full), .wlevel(wlevel),
    .woverflow(woverflow)
  );

  always #5 wclk = ~wclk;
  always #3.7 rclk = ~rclk;

  // asynchronous reader: Gray steps of one, never past the accepted writes
  always @(posedge rclk) begin
    if (!cdc_mode) rd_cnt_cdc = 0;
    else if (rd_cnt_cdc < acc_cnt && $urandom_range(0, 1) == 1) rd_cnt_cdc = rd_cnt_cdc + 1;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wcnt = 0; m_rs0 = 0; m_rs1 = 0; m_full = 0; m_ovf = 0;
    sb_q.delete();
  endtask

  // push the outputs expected after the coming edge for the inputs now driven
  task automatic model_step(input bit w, input bit clr, input int rd);
    exp_t e;
    int lvl;
    bit acc;
    acc = w && (m_full == 0);
    if (w && m_full == 1) m_ovf = 1;
    else if (clr) m_ovf = 0;
    m_wcnt = m_wcnt + (acc ? 1 : 0);
    lvl = m_wcnt - m_rs1;
    m_full = (lvl == 16) ? 1 : 0;
    m_rs1 = m_rs0;
    m_rs0 = rd;
    e.lvl = lvl; e.full = m_full; e.af = (lvl >= 12) ? 1 : 0; e.ovf = m_ovf;
    e.addr = m_wcnt % 16; e.ptr = int'(gray5(m_wcnt));
    sb_q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      chk("sb_wlevel", int'(wlevel), e.lvl);
      chk("sb_wfull", int'(wfull), e.full);
      chk("sb_walmost_full", int'(walmost_full), e.af);
      chk("sb_woverflow", int'(woverflow), e.ovf);
      chk("sb_waddr", int'(waddr), e.addr);
      chk("sb_wptr", int'(wptr), e.ptr);
    end
  endtask

  // one driven cycle: inputs now, model push, edge, scoreboard compare
  task automatic drive_cycle(input bit w, input bit clr, input int rd);
    winc = w; wovf_clr = clr; rd_cnt_main = rd;
    model_step(w, clr, rd);
    @(posedge wclk); #1;
    sb_check();
  endtask

  task automatic do_reset(input bit mid_clock);
    if (mid_clock) begin
      @(posedge wclk); #3;
      wrst_n = 1'b0;
      #1;
      chk("rst_async_waddr", int'(waddr), 0);
      chk("rst_async_wptr", int'(wptr), 0);
      chk("rst_async_wfull", int'(wfull), 0);
      chk("rst_async_walmost_full", int'(walmost_full), 0);
      chk("rst_async_wlevel", int'(wlevel), 0);
      chk("rst_async_woverflow", int'(woverflow), 0);
    end else begin
      wrst_n = 1'b0;
    end
    winc = 1'b0; wovf_clr = 1'b0; rd_cnt_main = 0; cdc_mode = 1'b0; acc_cnt = 0;
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
    model_reset();
    @(posedge wclk); #1;
    chk("rst_rel_waddr", int'(waddr), 0);
    chk("rst_rel_wptr", int'(wptr), 0);
    chk("rst_rel_wfull", int'(wfull), 0);
    chk("rst_rel_wlevel", int'(wlevel), 0);
  endtask

  initial begin
    int prev_full;
    int exp_clken;
    int wraps;
    logic [4:0] prev_ptr;
    logic [3:0] prev_addr;
    bit acc;
    int occ;

    // fill 16, overflow 3, clear tests, then drain via rptr=4 and rptr=5
    for (int i = 0; i < 16; i++)
      vecs[i] = '{1'b1, 1'b0, 0, i + 1, (i == 15) ? 1 : 0, (i >= 11) ? 1 : 0, 0};
    for (int i = 16; i < 19; i++) vecs[i] = '{1'b1, 1'b0, 0, 16, 1, 1, 1};
    vecs[19] = '{1'b1, 1'b1, 0, 16, 1, 1, 1};
    vecs[20] = '{1'b0, 1'b1, 0, 16, 1, 1, 0};
    vecs[21] = '{1'b0, 1'b0, 0, 16, 1, 1, 0};
    vecs[22] = '{1'b0, 1'b0, 4, 16, 1, 1, 0};
    vecs[23] = '{1'b0, 1'b0, 4, 16, 1, 1, 0};
    vecs[24] = '{1'b0, 1'b0, 4, 12, 0, 1, 0};
    vecs[25] = '{1'b0, 1'b0, 5, 12, 0, 1, 0};
    vecs[26] = '{1'b0, 1'b0, 5, 12, 0, 1, 0};
    vecs[27] = '{1'b0, 1'b0, 5, 11, 0, 0, 0};

    winc = 1'b0; wovf_clr = 1'b0;
    do_reset(1'b0);

    prev_full = 0;
    for (int i = 0; i < 28; i++) begin
      winc = vecs[i].winc; wovf_clr = vecs[i].clr; rd_cnt_main = vecs[i].rd;
      model_step(vecs[i].winc, vecs[i].clr, vecs[i].rd);
      #1;
      exp_clken = (vecs[i].winc && prev_full == 0) ? 1 : 0;
      chk("tbl_wclken", int'(wclken), exp_clken);
      @(posedge wclk); #1;
      sb_check();
      chk("tbl_wlevel", int'(wlevel), vecs[i].e_lvl);
      chk("tbl_wfull", int'(wfull), vecs[i].e_full);
      chk("tbl_walmost_full", int'(walmost_full), vecs[i].e_af);
      chk("tbl_woverflow", int'(woverflow), vecs[i].e_ovf);
      if (i == 15) begin
        chk("full_wptr", int'(wptr), 24);
        chk("full_waddr", int'(waddr), 0);
      end
      if (i >= 16 && i <= 18) chk("ovf_wptr_hold", int'(wptr), 24);
      prev_full = vecs[i].e_full;
    end

    // mid-clock reset from a non-zero state, then the wrap sequence
    do_reset(1'b1);
    wraps = 0;
    prev_ptr = wptr;
    prev_addr = waddr;
    for (int k = 0; k < 40; k++) begin
      drive_cycle(1'b1, 1'b0, (k >= 2) ? k - 2 : 0);
      chk("wrap_hamming", $countones(prev_ptr ^ wptr), 1);
      chk("wrap_no_full", int'(wfull), 0);
      if (prev_addr == 4'd15 && waddr == 4'd0) wraps++;
      prev_ptr = wptr;
      prev_addr = waddr;
    end
    chk("wrap_count", wraps, 2);
    chk("wrap_wptr_final", int'(wptr), int'(gray5(40)));

    // asynchronous reader on an unrelated clock
    do_reset(1'b1);
    wovf_clr = 1'b1;
    cdc_mode = 1'b1;
    for (int c = 0; c < 800; c++) begin
      winc = ($urandom_range(0, 3) != 0);
      #1;
      acc = wclken;
      @(posedge wclk);
      if (acc) acc_cnt++;
      #1;
      occ = acc_cnt - rd_cnt_cdc;
      chk("cdc_occ_le_depth", (occ <= 16) ? 1 : 0, 1);
      chk("cdc_level_ge_occ", (int'(wlevel) >= occ) ? 1 : 0, 1);
      chk("cdc_waddr", int'(waddr), acc_cnt % 16);
    end
    winc = 1'b0;
    cdc_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
